mul_div_sequencer: RTL and testbench
====================================

Name: mul_div_sequencer

Overview:
- Hardwired control FSM that drives the Phase-1 Datapath through one complete MUL or DIV instruction: fetch T0–T2, then execute T3–T6.
- Replaces hand-written bench stimulus on the Datapath `enable`, `busSelect`, `Control_Signals` and `MD_Read` inputs.
- Handles the memory-ready stall in T1, multi-cycle ALU latency in T4, and illegal-opcode abort.

Parameters:
- MUL_OPC, 5'b01111, IR[31:27] value for mul
- DIV_OPC, 5'b10000, IR[31:27] value for div
- ALU_MUL, 4'd12, Control_Signals code for multiply
- ALU_DIV, 4'd13, Control_Signals code for divide
- MUL_LAT, 1, T4 cycles for multiply (legal range 1..15)
- DIV_LAT, 4, T4 cycles for divide (legal range 1..15)

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  reset, asynchronous, active-low
- start  input  1  begin instruction; sampled in IDLE and T6 only
- mem_rdy  input  1  memory data valid on MDataIn
- ir  input  32  Datapath IR register contents
- enable  output  32  Datapath register load enables
- busSelect  output  32  Datapath bus driver selects
- Control_Signals  output  4  ALU operation select
- MD_Read  output  1  MDR mux selects memory input
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse in T6
- illegal  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Bit map, enable: [0..15] R0–R15, [16] HI, [17] LO, [20] PC, [21] MDR, [23] IR, [24] Z, [25] MAR, [27] Y, [28] IncPC.
- Bit map, busSelect: [0..15] R0–R15 out, [18] Zhigh, [19] Zlow, [20] PC, [21] MDR.
- Moore outputs decoded from the state register and latched fields only. Any bit not listed for a state is 0.
- Reset: clr=0 immediately forces state=IDLE and every output to 0, including mid-instruction. Latched fields and the counter clear to 0.
- IDLE: all outputs 0. start=1 at a rising edge → T0.
- T0: busSelect[20], enable[25], enable[28], enable[24]. Next state T1.
- T1: busSelect[19], enable[20], enable[21], MD_Read.
  - Remain in T1 while mem_rdy=0; outputs stay asserted.
  - mem_rdy=1 → T2.
- T2: busSelect[21], enable[23]. Next state T3; IR updates at this edge.
- T3: decode ir[31:27].
  - Not MUL_OPC or DIV_OPC: no datapath bits asserted; illegal=1; next state IDLE.
  - Otherwise: latch ra=ir[26:23], rb=ir[22:19], op. Load cnt with MUL_LAT-1 or DIV_LAT-1. Assert busSelect[ir[26:23]] and enable[27]. Next state T4.
- T4: busSelect[rb], enable[24], Control_Signals=ALU_MUL or ALU_DIV.
  - cnt≠0: decrement, stay in T4.
  - cnt=0: → T5.
  - Total T4 dwell = MUL_LAT or DIV_LAT cycles.
- T5: busSelect[19], enable[17]. Next state T6.
- T6: busSelect[18], enable[16], done=1.
  - start=1 → T0 (back-to-back, no IDLE cycle).
  - start=0 → IDLE.
- start is ignored in T0–T5.
- ra=rb is legal; the same register is used for both operands.
- Changes on ir after T3 have no effect, because fields are latched.
- Latency with mem_rdy held high, start edge to done: 6 + LAT cycles.
  - MUL (LAT=1): done in the 7th cycle after the start edge.
  - DIV (LAT=4): done in the 10th cycle after the start edge.
- mem_rdy is ignored outside T1.
- busy=0 only in IDLE, including the cycle in which illegal pulses.

Test Plan:
- Reset mid-T4 (clr=0 asynchronously) → all outputs 0 before the next edge; state IDLE; start afterwards runs a full instruction.
- mem_rdy=1, ir=32'h7B380000, start pulse → state order T0,T1,T2,T3,T4,T5,T6.
  - T3: busSelect[6] and enable[27].
  - T4: busSelect[7], enable[24], Control_Signals=12 for exactly 1 cycle.
  - done in T6; Datapath HI:LO = 6·7 (R6=6, R7=7 preloaded).
- DIV: ir=32'h80380000 (div R0,R7) → T4 lasts 4 cycles with Control_Signals=13; done 10 cycles after start.
- mem_rdy held 0 for 3 cycles in T1 → T1 lasts 4 cycles with MD_Read and enable[21] steady; T2 follows the mem_rdy=1 edge.
- ir[31:27]=5'b00011 → illegal pulses in T3; no enable bits assert in T3–T6; returns to IDLE; done never asserts.
- start held high through two instructions → T6 goes directly to T0; done pulses twice, 7 cycles apart (MUL); start pulses in T2 are ignored.

Source files
------------

// File: rtl/mul_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_sequencer
// Brief    : Hardwired fetch/execute control FSM steering the Phase-1
//            datapath through one MUL or DIV instruction (T0..T6).
// Revision : 1.0  initial release
// ============================================================================
module mul_div_sequencer #(
  parameter logic [4:0]  MUL_OPC = 5'b01111,
  parameter logic [4:0]  DIV_OPC = 5'b10000,
  parameter logic [3:0]  ALU_MUL = 4'd12,
  parameter logic [3:0]  ALU_DIV = 4'd13,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mem_rdy,
  input  logic [31:0] ir,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic [3:0]  Control_Signals,
  output logic        MD_Read,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  // enable bit positions
  localparam logic [4:0] c_en_hi    = 5'd16;
  localparam logic [4:0] c_en_lo    = 5'd17;
  localparam logic [4:0] c_en_pc    = 5'd20;
  localparam logic [4:0] c_en_mdr   = 5'd21;
  localparam logic [4:0] c_en_ir    = 5'd23;
  localparam logic [4:0] c_en_z     = 5'd24;
  localparam logic [4:0] c_en_mar   = 5'd25;
  localparam logic [4:0] c_en_y     = 5'd27;
  localparam logic [4:0] c_en_incpc = 5'd28;
  // busSelect bit positions
  localparam logic [4:0] c_bs_zhi   = 5'd18;
  localparam logic [4:0] c_bs_zlo   = 5'd19;
  localparam logic [4:0] c_bs_pc    = 5'd20;
  localparam logic [4:0] c_bs_mdr   = 5'd21;

  // T4 counter preloads: dwell is LAT cycles, so the counter runs LAT-1 .. 0
  localparam logic [3:0] c_mul_cnt = 4'(MUL_LAT - 1);
  localparam logic [3:0] c_div_cnt = 4'(DIV_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_ra;
  logic [3:0] r_rb;
  logic       r_is_div;
  logic [3:0] r_cnt;

  logic       w_is_mul;
  logic       w_is_div;
  logic       w_legal;
  logic       w_unused_bits;

  assign w_is_mul      = (ir[31:27] == MUL_OPC);
  assign w_is_div      = (ir[31:27] == DIV_OPC);
  assign w_legal       = w_is_mul | w_is_div;
  assign w_unused_bits = ^{ir[18:0], r_ra};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state  <= S_IDLE;
      r_ra     <= 4'd0;
      r_rb     <= 4'd0;
      r_is_div <= 1'b0;
      r_cnt    <= 4'd0;
    end else begin
      r_state <= w_next_state;
      // Operand fields are captured once so later IR changes cannot disturb T4..T6
      if (r_state == S_T3 && w_legal) begin
        r_ra     <= ir[26:23];
        r_rb     <= ir[22:19];
        r_is_div <= w_is_div;
        r_cnt    <= w_is_div ? c_div_cnt : c_mul_cnt;
      end else if (r_state == S_T4 && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_next_state    = r_state;
    enable          = 32'd0;
    busSelect       = 32'd0;
    Control_Signals = 4'd0;
    MD_Read         = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next_state = S_T0;
      end
      S_T0: begin
        busSelect[c_bs_pc]  = 1'b1;
        enable[c_en_mar]    = 1'b1;
        enable[c_en_incpc]  = 1'b1;
        enable[c_en_z]      = 1'b1;
        w_next_state        = S_T1;
      end
      S_T1: begin
        busSelect[c_bs_zlo] = 1'b1;
        enable[c_en_pc]     = 1'b1;
        enable[c_en_mdr]    = 1'b1;
        MD_Read             = 1'b1;
        if (mem_rdy) w_next_state = S_T2;
      end
      S_T2: begin
        busSelect[c_bs_mdr] = 1'b1;
        enable[c_en_ir]     = 1'b1;
        w_next_state        = S_T3;
      end
      S_T3: begin
        if (w_legal) begin
          busSelect[{1'b0, ir[26:23]}] = 1'b1;
          enable[c_en_y]               = 1'b1;
          w_next_state                 = S_T4;
        end else begin
          illegal      = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      S_T4: begin
        busSelect[{1'b0, r_rb}] = 1'b1;
        enable[c_en_z]          = 1'b1;
        Control_Signals         = r_is_div ? ALU_DIV : ALU_MUL;
        if (r_cnt == 4'd0) w_next_state = S_T5;
      end
      S_T5: begin
        busSelect[c_bs_zlo] = 1'b1;
        enable[c_en_lo]     = 1'b1;
        w_next_state        = S_T6;
      end
      S_T6: begin
        busSelect[c_bs_zhi] = 1'b1;
        enable[c_en_hi]     = 1'b1;
        done                = 1'b1;
        w_next_state        = start ? S_T0 : S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mul_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_sequencer
// Brief    : Directed, table-driven bench for mul_div_sequencer with a small
//            behavioural Phase-1 datapath model driven by the DUT controls.
// Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [31:0] ir = 32'd0;
  logic [31:0] enable;
  logic [31:0] busSelect;
  logic [3:0]  Control_Signals;
  logic        MD_Read;
  logic        busy;
  logic        done;
  logic        illegal;

  mul_div_sequencer dut (
    .clk             (clk),
    .clr             (clr),
    .start           (start),
    .mem_rdy         (mem_rdy),
    .ir              (ir),
    .enable          (enable),
    .busSelect       (busSelect),
    .Control_Signals (Control_Signals),
    .MD_Read         (MD_Read),
    .busy            (busy),
    .done            (done),
    .illegal         (illegal)
  );

  always #5 clk = ~clk;

  // Expected full output words per state
  localparam logic [31:0] E_T0  = (32'd1 << 25) | (32'd1 << 28) | (32'd1 << 24);
  localparam logic [31:0] E_T1  = (32'd1 << 20) | (32'd1 << 21);
  localparam logic [31:0] E_IR  = 32'd1 << 23;
  localparam logic [31:0] E_Y   = 32'd1 << 27;
  localparam logic [31:0] E_Z   = 32'd1 << 24;
  localparam logic [31:0] E_LO  = 32'd1 << 17;
  localparam logic [31:0] E_HI  = 32'd1 << 16;
  localparam logic [31:0] B_PC  = 32'd1 << 20;
  localparam logic [31:0] B_ZLO = 32'd1 << 19;
  localparam logic [31:0] B_ZHI = 32'd1 << 18;
  localparam logic [31:0] B_MDR = 32'd1 << 21;

  // Behavioural datapath: registers load from the bus under DUT control
  logic [31:0] R [16];
  logic [31:0] hi_r, lo_r, y_r, pc_r, mdr_r, bus;
  logic [63:0] z_r;
  logic        pre = 1'b0;
  logic [3:0]  pa = 4'd0, pb = 4'd0;
  logic [31:0] va = 32'd0, vb = 32'd0;

  always_comb begin
    bus = 32'd0;
    for (int i = 0; i < 16; i++) if (busSelect[i]) bus = bus | R[i];
    if (busSelect[18]) bus = bus | z_r[63:32];
    if (busSelect[19]) bus = bus | z_r[31:0];
    if (busSelect[20]) bus = bus | pc_r;
    if (busSelect[21]) bus = bus | mdr_r;
  end

  always @(posedge clk) begin
    if (pre) begin
      R[pa] <= va;
      R[pb] <= vb;
    end
    for (int i = 0; i < 16; i++) if (enable[i]) R[i] <= bus;
    if (enable[16]) hi_r  <= bus;
    if (enable[17]) lo_r  <= bus;
    if (enable[20]) pc_r  <= bus;
    if (enable[21]) mdr_r <= MD_Read ? 32'd0 : bus;
    if (enable[27]) y_r   <= bus;
    if (enable[24]) begin
      case (Control_Signals)
        4'd12:   z_r <= {32'd0, y_r} * {32'd0, bus};
        4'd13:   z_r <= (bus == 32'd0) ? 64'd0 : {y_r % bus, y_r / bus};
        default: z_r <= {32'd0, bus + 32'd1};
      endcase
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // State code recovered from outputs: 0 IDLE, 1..7 T0..T6, 15 unrecognised
  function automatic int classify(input logic [3:0] ra, input logic [3:0] rb,
                                  input logic [3:0] ctrl, input bit ill);
    logic quiet;
    quiet = !MD_Read && !done && !illegal && (Control_Signals == 4'd0);
    if (!busy) return (quiet && enable == 32'd0 && busSelect == 32'd0) ? 0 : 15;
    if (quiet && enable == E_T0 && busSelect == B_PC) return 1;
    if (!done && !illegal && Control_Signals == 4'd0 && MD_Read &&
        enable == E_T1 && busSelect == B_ZLO) return 2;
    if (quiet && enable == E_IR && busSelect == B_MDR) return 3;
    if (ill) begin
      if (!MD_Read && !done && illegal && Control_Signals == 4'd0 &&
          enable == 32'd0 && busSelect == 32'd0) return 4;
    end else if (quiet && enable == E_Y && busSelect == (32'd1 << ra)) return 4;
    if (!MD_Read && !done && !illegal && Control_Signals == ctrl &&
        enable == E_Z && busSelect == (32'd1 << rb)) return 5;
    if (quiet && enable == E_LO && busSelect == B_ZLO) return 6;
    if (!MD_Read && done && !illegal && Control_Signals == 4'd0 &&
        enable == E_HI && busSelect == B_ZHI) return 7;
    return 15;
  endfunction

  typedef struct {
    logic [31:0] ir;
    int          stall;
    bit          noise;
    bit          ill;
    int          lat;
    logic [3:0]  ctrl;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_done;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t tbl [7];

  task automatic preload(input vec_t v);
    pa = v.ra; pb = v.rb; va = v.a; vb = v.b; pre = 1'b1;
    @(posedge clk); #1;
    pre = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int exp_q[$];
    int k, st, t1n, done_cyc, done_n, ill_n, bad_got, bad_exp;
    bit order_ok, fin;
    exp_q.push_back(1);
    for (int i = 0; i <= v.stall; i++) exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(4);
    if (!v.ill) begin
      for (int i = 0; i < v.lat; i++) exp_q.push_back(5);
      exp_q.push_back(6);
      exp_q.push_back(7);
    end
    exp_q.push_back(0);
    preload(v);
    ir = v.ir; start = 1'b1; mem_rdy = 1'b0;
    k = 0; t1n = 0; done_cyc = 0; done_n = 0; ill_n = 0;
    order_ok = 1'b1; fin = 1'b0; bad_got = 0; bad_exp = 0;
    while (!fin && k < 40) begin
      @(posedge clk); #1;
      k++;
      st = classify(v.ra, v.rb, v.ctrl, v.ill);
      if (k > exp_q.size() || st != exp_q[(k > exp_q.size()) ? 0 : k-1]) begin
        if (order_ok) begin
          bad_got = 100*k + st;
          bad_exp = 100*k + ((k > exp_q.size()) ? 0 : exp_q[k-1]);
        end
        order_ok = 1'b0;
      end
      if (done) begin done_cyc = k; done_n++; end
      if (illegal) ill_n++;
      start = (v.noise && st >= 1 && st <= 6);
      if (st == 2) begin
        t1n++;
        mem_rdy = (t1n > v.stall);
      end else begin
        mem_rdy = (k % 2 == 1);
      end
      if (v.noise && st == 5) ir = 32'hDEADBEEF;
      if (st == 0) fin = 1'b1;
    end
    start = 1'b0; ir = 32'd0;
    if (order_ok && k != exp_q.size()) begin bad_got = k; bad_exp = exp_q.size(); end
    chk(order_ok && k == exp_q.size(), $sformatf("v%0d_state_order", id), bad_got, bad_exp);
    chk(done_cyc == v.exp_done && done_n == (v.ill ? 0 : 1),
        $sformatf("v%0d_done_cycle", id), done_cyc, v.exp_done);
    chk(ill_n == (v.ill ? 1 : 0), $sformatf("v%0d_illegal_pulses", id), ill_n, v.ill ? 1 : 0);
    if (!v.ill) begin
      chk(hi_r == v.exp_hi, $sformatf("v%0d_hi", id), hi_r, v.exp_hi);
      chk(lo_r == v.exp_lo, $sformatf("v%0d_lo", id), lo_r, v.exp_lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int st, k, dn;
    int done_q[$];
    int t0_q[$];

    //            ir            stl nz il lat ctrl   ra    rb    a             b        done hi     lo
    tbl[0] = '{32'h7B380000, 0, 0, 0, 1, 4'd12, 4'd6, 4'd7, 32'd6,         32'd7,      7, 32'd0, 32'd42};
    tbl[1] = '{32'h80380000, 0, 0, 0, 4, 4'd13, 4'd0, 4'd7, 32'd20,        32'd6,     10, 32'd2, 32'd3};
    tbl[2] = '{32'h7B380000, 3, 0, 0, 1, 4'd12, 4'd6, 4'd7, 32'd100000,    32'd300000, 10, 32'd6, 32'hFC23AC00};
    tbl[3] = '{32'h18000000, 0, 0, 1, 0, 4'd0,  4'd0, 4'd0, 32'd0,         32'd0,      0, 32'd0, 32'd0};
    tbl[4] = '{32'h82A80000, 0, 0, 0, 4, 4'd13, 4'd5, 4'd5, 32'd9,         32'd9,     10, 32'd0, 32'd1};
    tbl[5] = '{32'h79180000, 0, 1, 0, 1, 4'd12, 4'd2, 4'd3, 32'hFFFFFFFF,  32'd2,      7, 32'd1, 32'hFFFFFFFE};
    tbl[6] = '{32'hF8000000, 1, 0, 1, 0, 4'd0,  4'd0, 4'd0, 32'd0,         32'd0,      0, 32'd0, 32'd0};

    #12;
    st = classify(4'd0, 4'd0, 4'd0, 1'b0);
    chk(st == 0, "reset_state", st, 0);
    #5 clr = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(tbl[i], i);

    // Asynchronous reset in the middle of a DIV T4 dwell
    preload(tbl[1]);
    ir = tbl[1].ir; start = 1'b1; mem_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    st = classify(tbl[1].ra, tbl[1].rb, tbl[1].ctrl, 1'b0);
    chk(st == 5, "pre_reset_in_t4", st, 5);
    #3 clr = 1'b0;
    #1;
    st = classify(4'd0, 4'd0, 4'd0, 1'b0);
    chk(st == 0, "async_reset_outputs", st, 0);
    @(posedge clk); #1;
    st = classify(4'd0, 4'd0, 4'd0, 1'b0);
    chk(st == 0, "reset_hold_idle", st, 0);
    clr = 1'b1;
    run_vec(tbl[1], 10);

    // Back-to-back MULs with start held high throughout
    preload(tbl[0]);
    ir = tbl[0].ir; start = 1'b1; mem_rdy = 1'b1;
    k = 0; dn = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      st = classify(tbl[0].ra, tbl[0].rb, tbl[0].ctrl, 1'b0);
      if (done) begin done_q.push_back(k); dn++; end
      if (st == 1) t0_q.push_back(k);
      if (st == 7 && dn == 2) start = 1'b0;
      if (st == 0) break;
    end
    start = 1'b0;
    chk(dn == 2, "b2b_done_count", dn, 2);
    chk(done_q.size() >= 1 && done_q[0] == 7, "b2b_first_done",
        (done_q.size() >= 1) ? done_q[0] : 0, 7);
    chk(done_q.size() >= 2 && done_q[1] == 14, "b2b_second_done",
        (done_q.size() >= 2) ? done_q[1] : 0, 14);
    chk(t0_q.size() == 2 && t0_q[1] == 8, "b2b_t6_to_t0",
        (t0_q.size() >= 2) ? t0_q[1] : 0, 8);
    chk(lo_r == 32'd42 && hi_r == 32'd0, "b2b_hilo", {hi_r, lo_r}, 64'd42);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
